wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 40 ++++
 rtl/wb_arbiter.sv | 84 ++++++++
 tb/tb_wb_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback bus between the ALU/load-unit requesters, the issue stage and the register file.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface wb_arbiter_if;
    logic        alu_req;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ack;

    logic        mem_req;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ack;

    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;

    logic        rd_w;
    logic [4:0]  rd_addr;
    logic [31:0] rd;

    modport slave (
        input  alu_req, alu_addr, alu_data,
        input  mem_req, mem_addr, mem_data,
        input  iss_valid, iss_addr, rs1_addr, rs2_addr,
        output alu_ack, mem_ack, rs1_busy, rs2_busy,
        output rd_w, rd_addr, rd
    );

    modport master (
        output alu_req, alu_addr, alu_data,
        output mem_req, mem_addr, mem_data,
        output iss_valid, iss_addr, rs1_addr, rs2_addr,
        input  alu_ack, mem_ack, rs1_busy, rs2_busy,
        input  rd_w, rd_addr, rd
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter between ALU and load unit, driving a registered
// register-file write port and a 32-entry pending-write scoreboard.
module wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    grant_e      r_last_grant;
    logic        r_rd_w;
    logic [4:0]  r_rd_addr;
    logic [31:0] r_rd;
    logic [31:0] r_pending;

    logic        w_grant_alu;
    logic        w_grant_mem;
    logic        w_grant;
    logic [4:0]  w_win_addr;
    logic [31:0] w_win_data;
    logic [31:0] w_pending_next;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
        if (!rst) begin
            if (bus.alu_req && bus.mem_req) begin
                w_grant_alu = (r_last_grant == GRANT_MEM);
                w_grant_mem = (r_last_grant == GRANT_ALU);
            end else begin
                w_grant_alu = bus.alu_req;
                w_grant_mem = bus.mem_req;
            end
        end
    end

    assign w_grant    = w_grant_alu | w_grant_mem;
    assign w_win_addr = w_grant_alu ? bus.alu_addr : bus.mem_addr;
    assign w_win_data = w_grant_alu ? bus.alu_data : bus.mem_data;

    // Clear from the retiring write first, then the issue set, so a same-address set wins.
    always_comb begin
        w_pending_next = r_pending;
        if (w_grant) begin
            w_pending_next[w_win_addr] = 1'b0;
        end
        if (bus.iss_valid) begin
            w_pending_next[bus.iss_addr] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the pending bits are real state that must read clear after reset, so the whole array is reset.
            r_last_grant <= GRANT_MEM;
            r_rd_w       <= 1'b0;
            r_rd_addr    <= 5'd0;
            r_rd         <= 32'd0;
            r_pending    <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_rd_w    <= w_grant && (w_win_addr != 5'd0);
            r_pending <= w_pending_next;
            if (w_grant) begin
                r_last_grant <= w_grant_alu ? GRANT_ALU : GRANT_MEM;
                r_rd_addr    <= w_win_addr;
                r_rd         <= w_win_data;
            end
        end
    end

    assign bus.alu_ack  = w_grant_alu;
    assign bus.mem_ack  = w_grant_mem;
    assign bus.rs1_busy = r_pending[bus.rs1_addr];
    assign bus.rs2_busy = r_pending[bus.rs2_addr];
    assign bus.rd_w     = r_rd_w;
    assign bus.rd_addr  = r_rd_addr;
    assign bus.rd       = r_rd;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a reference model queues expected register writes,
// a monitor pops them when rd_w appears; acks and busy flags are compared every cycle.
`timescale 1ns/1ps
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_front;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;

    // Reference model state: pending set as a plain bit array and who won last.
    bit [31:0]   m_pend     = '0;
    bit          m_last_alu = 1'b0;
    bit          e_alu;
    bit          e_mem;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: decides the winner from the arbitration rules and queues the write.
    always @(negedge clk) begin
        if (rst) begin
            check("alu_ack_in_reset", bus.alu_ack, 0);
            check("mem_ack_in_reset", bus.mem_ack, 0);
            check("rs1_busy_in_reset", bus.rs1_busy, 0);
            check("rs2_busy_in_reset", bus.rs2_busy, 0);
            m_pend     = '0;
            m_last_alu = 1'b0;
            exp_q.delete();
        end else begin
            if (bus.alu_req && bus.mem_req) begin
                e_alu = !m_last_alu;
                e_mem = m_last_alu;
            end else begin
                e_alu = bus.alu_req;
                e_mem = bus.mem_req;
            end
            check("alu_ack", bus.alu_ack, e_alu);
            check("mem_ack", bus.mem_ack, e_mem);
            check("rs1_busy", bus.rs1_busy, (bus.rs1_addr == 0) ? 0 : m_pend[bus.rs1_addr]);
            check("rs2_busy", bus.rs2_busy, (bus.rs2_addr == 0) ? 0 : m_pend[bus.rs2_addr]);
            if (e_alu || e_mem) begin
                m_last_alu = e_alu;
                if (e_alu && bus.alu_addr != 0) begin
                    exp_q.push_back('{cyc, bus.alu_addr, bus.alu_data});
                    m_pend[bus.alu_addr] = 1'b0;
                end
                if (e_mem && bus.mem_addr != 0) begin
                    exp_q.push_back('{cyc, bus.mem_addr, bus.mem_data});
                    m_pend[bus.mem_addr] = 1'b0;
                end
            end
            if (bus.iss_valid && bus.iss_addr != 0) m_pend[bus.iss_addr] = 1'b1;
        end
    end

    // Monitor: a write queued last cycle must appear now; otherwise rd_w must be low.
    always @(negedge clk) begin
        if (rst) begin
            check("rd_w_in_reset", bus.rd_w, 0);
            check("rd_addr_in_reset", bus.rd_addr, 0);
            check("rd_in_reset", bus.rd, 0);
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc - 1) begin
            e_front = exp_q.pop_front();
            check("rd_w", bus.rd_w, 1);
            check("rd_addr", bus.rd_addr, e_front.addr);
            check("rd", bus.rd, e_front.data);
        end else begin
            check("rd_w_idle", bus.rd_w, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1);
    end

    task automatic tick(output bit a, output bit m);
        @(negedge clk);
        a = bus.alu_ack;
        m = bus.mem_ack;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit a, m;
        for (int n = 0; n < 8 && (bus.alu_req || bus.mem_req); n++) begin
            tick(a, m);
            bus.iss_valid = 1'b0;
            if (a) bus.alu_req = 1'b0;
            if (m) bus.mem_req = 1'b0;
        end
        check("drain_timeout", {bus.alu_req, bus.mem_req}, 0);
    endtask

    task automatic run_reqs(input bit ar, input logic [4:0] aa, input logic [31:0] ad,
                            input bit mr, input logic [4:0] ma, input logic [31:0] md);
        bus.alu_req  = ar;
        bus.alu_addr = aa;
        bus.alu_data = ad;
        bus.mem_req  = mr;
        bus.mem_addr = ma;
        bus.mem_data = md;
        drain();
    endtask

    function automatic logic [4:0] rand_addr();
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        bit a, m;
        int rst_left;
        bus.alu_req = 1'b1;  bus.alu_addr = 5'd1; bus.alu_data = 32'hdead_beef;
        bus.mem_req = 1'b1;  bus.mem_addr = 5'd2; bus.mem_data = 32'hcafe_f00d;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd3;
        bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd1;

        // Requests held during reset must not be acked.
        repeat (3) tick(a, m);
        bus.alu_req = 1'b0; bus.mem_req = 1'b0; bus.iss_valid = 1'b0;
        rst = 1'b0;
        tick(a, m);

        // Single ALU request, then an idle cycle.
        run_reqs(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        tick(a, m);

        // Make MEM the last winner, then a held tie must go ALU then MEM.
        run_reqs(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h2222);
        run_reqs(1'b1, 5'd3, 32'h3333_0003, 1'b1, 5'd4, 32'h4444_0004);
        tick(a, m);

        // Issue marks r7 busy; a MEM write to r7 clears it.
        bus.rs1_addr = 5'd7; bus.iss_valid = 1'b1; bus.iss_addr = 5'd7;
        tick(a, m);
        bus.iss_valid = 1'b0;
        tick(a, m);
        run_reqs(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7777_7777);
        tick(a, m);

        // Set and clear on r9 in the same edge: set wins, write still happens.
        bus.rs2_addr = 5'd9; bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
        run_reqs(1'b1, 5'd9, 32'h9999_0009, 1'b0, 5'd0, 32'd0);
        repeat (2) tick(a, m);

        // Register 0: acked but never written, never busy.
        bus.rs2_addr = 5'd0; bus.iss_valid = 1'b1; bus.iss_addr = 5'd0;
        run_reqs(1'b1, 5'd0, 32'hffff_ffff, 1'b0, 5'd0, 32'd0);
        repeat (2) tick(a, m);

        // Fill the scoreboard, start grants, then reset mid-operation.
        for (int i = 1; i < 32; i++) begin
            bus.iss_valid = 1'b1; bus.iss_addr = 5'(i);
            bus.rs1_addr = 5'(i - 1); bus.rs2_addr = 5'(i);
            tick(a, m);
        end
        bus.iss_valid = 1'b0;
        bus.rs1_addr = 5'd10; bus.rs2_addr = 5'd20;
        bus.alu_req = 1'b1; bus.alu_addr = 5'd10; bus.alu_data = 32'haaaa_000a;
        bus.mem_req = 1'b1; bus.mem_addr = 5'd20; bus.mem_data = 32'hbbbb_0014;
        tick(a, m);
        rst = 1'b1;
        repeat (2) tick(a, m);
        bus.alu_addr = 5'd11; bus.mem_addr = 5'd12;
        rst = 1'b0;
        drain();
        tick(a, m);

        // Randomized traffic with occasional resets; requests held until acked.
        a = 1'b0; m = 1'b0; rst_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rst = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                rst_left = $urandom_range(1, 3);
                bus.alu_req = 1'b0;
                bus.mem_req = 1'b0;
            end
            if (!rst) begin
                if (!bus.alu_req || a) begin
                    bus.alu_req  = ($urandom_range(0, 3) != 0);
                    bus.alu_addr = rand_addr();
                    bus.alu_data = $urandom();
                end
                if (!bus.mem_req || m) begin
                    bus.mem_req  = ($urandom_range(0, 3) != 0);
                    bus.mem_addr = rand_addr();
                    bus.mem_data = $urandom();
                end
            end
            bus.iss_valid = ($urandom_range(0, 2) == 0);
            bus.iss_addr  = rand_addr();
            bus.rs1_addr  = rand_addr();
            bus.rs2_addr  = rand_addr();
            tick(a, m);
        end
        rst = 1'b0;
        drain();
        bus.iss_valid = 1'b0;
        repeat (3) tick(a, m);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
